// File: rtl/rs_enc_sched_pkg.sv
// Shared constants and types for the RS(544,514) encoder scheduler.
//   RS_K / RS_N / RS_NSYM : message, codeword and parity symbol counts
//   RS_SYM_W              : GF(2^10) symbol width
//   rs_sched_state_t      : scheduler FSM states
package rs_pkg;
  localparam int RS_K     = 514;
  localparam int RS_N     = 544;
  localparam int RS_NSYM  = 30;
  localparam int RS_SYM_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    GAP,
    DRAIN
  } rs_sched_state_t;
endpackage

// File: rtl/rs_enc_sched_if.sv
// Link between the scheduler and the shared RS encoder.
//   sop, valid_in, data_in    : message symbols towards the encoder
//   ready                     : encoder idle / able to accept a message
//   valid_out, data_out       : codeword symbols returned by the encoder
// master = scheduler side, slave = encoder side.
interface rs_enc_sched_if;
  import rs_pkg::*;

  logic                sop;
  logic                valid_in;
  logic [RS_SYM_W-1:0] data_in;
  logic                ready;
  logic                valid_out;
  logic [RS_SYM_W-1:0] data_out;

  modport master (
    output sop, valid_in, data_in,
    input  ready, valid_out, data_out
  );

  modport slave (
    input  sop, valid_in, data_in,
    output ready, valid_out, data_out
  );
endinterface

// File: rtl/rs_enc_sched_rr_arbiter.sv
// Combinational round-robin pick.
//   req_masked : eligible lanes (request AND enable)
//   rr_ptr     : lane with highest priority this round
//   found      : at least one lane is eligible
//   winner     : first eligible lane at or after rr_ptr, wrapping upward
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LANE_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_masked,
  input  logic [LANE_W-1:0]  rr_ptr,
  output logic               found,
  output logic [LANE_W-1:0]  winner
);
  // Rotate so that bit 0 corresponds to rr_ptr; the lowest set bit of the
  // rotated vector is then the offset of the winner from rr_ptr.
  logic [NUM_REQ-1:0] rotated;
  logic [LANE_W:0]    sum;

  assign rotated = NUM_REQ'({req_masked, req_masked} >> rr_ptr);

  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (rotated[off]) begin
        found = 1'b1;
        sum   = (LANE_W+1)'(rr_ptr) + (LANE_W+1)'(off);
        if (sum >= (LANE_W+1)'(NUM_REQ)) begin
          sum = sum - (LANE_W+1)'(NUM_REQ);
        end
        winner = sum[LANE_W-1:0];
      end
    end
  end
endmodule

// File: rtl/rs_enc_sched.sv
// Round-robin scheduler sharing one RS(544,514) encoder between NUM_REQ lanes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-lane "full message buffered" level request
//   lane_en     : per-lane arbitration enable
//   req_data    : per-lane symbol, lane i at [10i+9:10i]
//   gnt         : one-hot read strobe to the granted lane
//   enc         : encoder link (master side)
//   out_*       : codeword symbols tagged with lane, sop/eop framing
//   busy        : FSM not in IDLE
//   err_stray   : one-cycle pulse for an encoder output nobody expects
module rs_enc_sched
  import rs_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LANE_W  = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           lane_en,
  input  logic [NUM_REQ*RS_SYM_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]           gnt,
  rs_enc_sched_if.master               enc,
  output logic                         out_valid,
  output logic [RS_SYM_W-1:0]          out_data,
  output logic [LANE_W-1:0]            out_lane,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic                         busy,
  output logic                         err_stray
);
  rs_sched_state_t     state;
  logic [LANE_W-1:0]   cur_lane;
  logic [LANE_W-1:0]   rr_ptr;
  logic [9:0]          in_cnt;
  logic [9:0]          out_cnt;
  logic                found;
  logic [LANE_W-1:0]   winner;
  logic [RS_SYM_W-1:0] lane_sym [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .LANE_W  (LANE_W)
  ) u_arb (
    .req_masked (req & lane_en),
    .rr_ptr     (rr_ptr),
    .found      (found),
    .winner     (winner)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane_sym[gi] = req_data[gi*RS_SYM_W +: RS_SYM_W];
  end

  // Symbol path is a plain mux so the lane sees its gnt and supplies the
  // symbol in the same cycle; forced to zero outside a burst.
  assign enc.data_in = enc.valid_in ? lane_sym[cur_lane] : '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_lane     <= '0;
      rr_ptr       <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      gnt          <= '0;
      enc.sop      <= 1'b0;
      enc.valid_in <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_lane     <= '0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      enc.sop <= 1'b0;

      case (state)
        IDLE: begin
          if (enc.ready && found) begin
            state        <= FEED;
            cur_lane     <= winner;
            rr_ptr       <= (winner == LANE_W'(NUM_REQ - 1)) ? '0 : winner + LANE_W'(1);
            gnt          <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            enc.sop      <= 1'b1;
            enc.valid_in <= 1'b1;
            in_cnt       <= '0;
            // Encoder output may start while still feeding, so the
            // codeword count is armed at launch.
            out_cnt      <= '0;
          end
        end
        FEED: begin
          if (in_cnt == 10'(RS_K - 1)) begin
            state        <= GAP;
            in_cnt       <= '0;
            gnt          <= '0;
            enc.valid_in <= 1'b0;
          end else begin
            in_cnt <= in_cnt + 10'd1;
          end
        end
        GAP: begin
          state <= DRAIN;
        end
        DRAIN: begin
          if (out_cnt == 10'(RS_N) && enc.ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Codeword tagging: only the first RS_N symbols after a launch belong
      // to the in-flight codeword; anything else is flagged and dropped.
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      err_stray <= 1'b0;
      if (enc.valid_out) begin
        if (state != IDLE && out_cnt < 10'(RS_N)) begin
          out_valid <= 1'b1;
          out_data  <= enc.data_out;
          out_lane  <= cur_lane;
          out_sop   <= (out_cnt == 10'd0);
          out_eop   <= (out_cnt == 10'(RS_N - 1));
          out_cnt   <= out_cnt + 10'd1;
        end else begin
          err_stray <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_enc_sched.sv
module tb_rs_enc_sched;
  import rs_pkg::*;

  localparam int NR = 4;
  localparam int LW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     lane_en = 4'hF;
  logic [NR*10-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic              out_valid;
  logic [9:0]        out_data;
  logic [LW-1:0]     out_lane;
  logic              out_sop, out_eop, busy, err_stray;

  rs_enc_sched_if enc_if ();

  rs_enc_sched #(.NUM_REQ(NR), .LANE_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lane_en   (lane_en),
    .req_data  (req_data),
    .gnt       (gnt),
    .enc       (enc_if),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .busy      (busy),
    .err_stray (err_stray)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]    d;
    logic [LW-1:0] lane;
    logic          sop;
    logic          eop;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [LW-1:0] lane_q[$];
  int          lane_cnt[NR];
  bit          ready_en = 1'b1;
  bit          stray_req = 1'b0;
  int          bursts_started = 0;
  int          eops_seen = 0;
  int          stray_count = 0;
  int          rx_cnt_g = 0;
  bit          cw_open = 1'b0;

  // Lane i presents {lane, symbol index within its burst}.
  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    assign req_data[gi*10 +: 10] = {3'(gi), 7'(lane_cnt[gi])};
  end

  function automatic logic [9:0] cw_sym(int lane, int k);
    return 10'((k * 7 + lane * 131) % 1024);
  endfunction

  // Encoder model: checks bursts, then returns a 544-symbol codeword.
  initial begin : enc_model
    int            rx_cnt, tx_k;
    bit            rx_on, tx_on, bad_data, bad_gnt, bad_sop;
    logic [LW-1:0] lane_m;
    logic [NR-1:0] oh;
    exp_t          e;
    rx_cnt = 0; tx_k = 0; rx_on = 0; tx_on = 0;
    bad_data = 0; bad_gnt = 0; bad_sop = 0; lane_m = '0;
    for (int i = 0; i < NR; i++) lane_cnt[i] = 0;
    enc_if.ready = ready_en;
    enc_if.valid_out = 1'b0;
    enc_if.data_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        rx_on = 0; tx_on = 0; rx_cnt = 0; rx_cnt_g = 0;
        for (int i = 0; i < NR; i++) lane_cnt[i] = 0;
        enc_if.valid_out = 1'b0;
        enc_if.data_out = '0;
        enc_if.ready = ready_en;
        continue;
      end
      if (enc_if.valid_in) begin
        if (!rx_on) begin
          rx_on = 1; rx_cnt = 0; bad_data = 0; bad_gnt = 0; bad_sop = 0;
          bursts_started++;
          checks++;
          if (lane_q.size() == 0) begin
            failures++;
            $display("FAIL burst_unexpected: gnt=%b, required no grant", gnt);
            lane_m = '0;
          end else begin
            lane_m = lane_q.pop_front();
          end
          checks++;
          if (enc_if.sop !== 1'b1) begin
            failures++;
            $display("FAIL sop_first: enc_sop=%b required 1", enc_if.sop);
          end
          checks++;
          if (cw_open) begin
            failures++;
            $display("FAIL overlap: grant before previous out_eop, gnt=%b required 0", gnt);
          end
          $display("burst %0d start lane=%0d gnt=%b", bursts_started, lane_m, gnt);
        end else if (enc_if.sop) begin
          bad_sop = 1;
        end
        oh = '0;
        oh[lane_m] = 1'b1;
        if (gnt !== oh) bad_gnt = 1;
        if (enc_if.data_in !== {3'(lane_m), 7'(rx_cnt)}) bad_data = 1;
        rx_cnt++;
        rx_cnt_g = rx_cnt;
      end else if (rx_on) begin
        rx_on = 0;
        checks++;
        if (rx_cnt != 514) begin
          failures++;
          $display("FAIL burst_len: got %0d symbols required 514", rx_cnt);
        end
        checks++;
        if (bad_gnt || bad_data || bad_sop) begin
          failures++;
          $display("FAIL burst_content: gnt_err=%0d data_err=%0d sop_err=%0d required all 0",
                   bad_gnt, bad_data, bad_sop);
        end
        checks++;
        if (enc_if.data_in !== 10'd0 || gnt !== '0 || enc_if.sop !== 1'b0) begin
          failures++;
          $display("FAIL gap: data_in=%h gnt=%b sop=%b required 0/0/0",
                   enc_if.data_in, gnt, enc_if.sop);
        end
        tx_on = 1; tx_k = 0;
      end
      for (int i = 0; i < NR; i++) lane_cnt[i] = gnt[i] ? lane_cnt[i] + 1 : 0;
      if (tx_on) begin
        enc_if.valid_out = 1'b1;
        enc_if.data_out = cw_sym(int'(lane_m), tx_k);
        e.d = cw_sym(int'(lane_m), tx_k);
        e.lane = lane_m;
        e.sop = (tx_k == 0);
        e.eop = (tx_k == 543);
        exp_q.push_back(e);
        tx_k++;
        if (tx_k == 544) tx_on = 0;
      end else if (stray_req) begin
        enc_if.valid_out = 1'b1;
        enc_if.data_out = 10'h155;
        stray_req = 0;
      end else begin
        enc_if.valid_out = 1'b0;
        enc_if.data_out = '0;
      end
      enc_if.ready = ready_en && !rx_on && !tx_on;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a symbol.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cw_open = 0;
      end else begin
        if (err_stray) stray_count++;
        if (out_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected: data=%h lane=%0d, required no output", out_data, out_lane);
          end else begin
            e = exp_q.pop_front();
            if (out_data !== e.d || out_lane !== e.lane || out_sop !== e.sop || out_eop !== e.eop) begin
              failures++;
              $display("FAIL out_sym: got d=%h lane=%0d sop=%b eop=%b required d=%h lane=%0d sop=%b eop=%b",
                       out_data, out_lane, out_sop, out_eop, e.d, e.lane, e.sop, e.eop);
            end
          end
          if (out_sop) cw_open = 1;
          if (out_eop) begin
            cw_open = 0;
            eops_seen++;
            $display("codeword %0d done lane=%0d", eops_seen, out_lane);
          end
        end
      end
    end
  end

  task automatic check_zero(input string nm);
    checks++;
    if ({gnt, enc_if.sop, enc_if.valid_in, enc_if.data_in, out_valid, out_data,
         out_lane, out_sop, out_eop, busy, err_stray} !== '0) begin
      failures++;
      $display("FAIL %s: gnt=%b sop=%b vin=%b din=%h ov=%b od=%h ol=%0d os=%b oe=%b busy=%b stray=%b required all 0",
               nm, gnt, enc_if.sop, enc_if.valid_in, enc_if.data_in, out_valid, out_data,
               out_lane, out_sop, out_eop, busy, err_stray);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset_outs");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_bursts(input int n, input string nm);
    int t = 0;
    while (bursts_started < n && t < 5000) begin
      @(posedge clk);
      #2;
      t++;
    end
    checks++;
    if (bursts_started < n) begin
      failures++;
      $display("FAIL %s: bursts=%0d required %0d (timeout)", nm, bursts_started, n);
    end
  endtask

  task automatic wait_eops(input int n, input string nm);
    int t = 0;
    while ((eops_seen < n || busy) && t < 6000) begin
      @(posedge clk);
      #2;
      t++;
    end
    checks++;
    if (eops_seen < n || busy) begin
      failures++;
      $display("FAIL %s: eops=%0d busy=%b required %0d/0 (timeout)", nm, eops_seen, busy, n);
    end
  endtask

  initial begin : stim
    int b, e, s, t;
    bit bad;

    // Reset state
    do_reset();

    // Single lane 2
    b = bursts_started; e = eops_seen;
    lane_q.push_back(2'd2);
    req = 4'b0100;
    wait_bursts(b + 1, "single_grant");
    req = '0;
    wait_eops(e + 1, "single_done");

    // Round robin, all lanes requesting
    do_reset();
    b = bursts_started; e = eops_seen;
    lane_q.push_back(2'd0); lane_q.push_back(2'd1); lane_q.push_back(2'd2);
    lane_q.push_back(2'd3); lane_q.push_back(2'd0);
    req = 4'b1111;
    wait_bursts(b + 5, "rr_grants");
    req = '0;
    wait_eops(e + 5, "rr_done");

    // Masking
    do_reset();
    b = bursts_started; e = eops_seen;
    lane_en = 4'b1010;
    lane_q.push_back(2'd1); lane_q.push_back(2'd3); lane_q.push_back(2'd1);
    req = 4'b1111;
    wait_bursts(b + 3, "mask_grants");
    req = '0;
    wait_eops(e + 3, "mask_done");
    lane_en = 4'hF;

    // Encoder busy
    do_reset();
    ready_en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    b = bursts_started; e = eops_seen;
    lane_q.push_back(2'd0);
    req = 4'b0001;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (gnt !== '0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL busy_hold: gnt went nonzero while enc_ready=0, required 0");
    end
    ready_en = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (enc_if.ready !== 1'b1 || gnt !== 4'b0000) begin
      failures++;
      $display("FAIL busy_rise: ready=%b gnt=%b required 1/0000", enc_if.ready, gnt);
    end
    @(posedge clk);
    #2;
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL busy_grant: gnt=%b required 0001", gnt);
    end
    req = '0;
    wait_bursts(b + 1, "busy_burst");
    wait_eops(e + 1, "busy_done");

    // Stray encoder output in IDLE
    s = stray_count;
    stray_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (err_stray !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_pulse: err_stray=%b out_valid=%b required 1/0", err_stray, out_valid);
    end
    @(posedge clk);
    #2;
    checks++;
    if (err_stray !== 1'b0) begin
      failures++;
      $display("FAIL stray_width: err_stray=%b required 0", err_stray);
    end
    checks++;
    if (stray_count != s + 1) begin
      failures++;
      $display("FAIL stray_count: got %0d required %0d", stray_count, s + 1);
    end

    // Mid-burst reset
    b = bursts_started; e = eops_seen;
    lane_q.push_back(2'd0);
    req = 4'b0001;
    wait_bursts(b + 1, "mid_grant");
    t = 0;
    while (rx_cnt_g < 200 && t < 1000) begin
      @(posedge clk);
      #2;
      t++;
    end
    checks++;
    if (rx_cnt_g < 200) begin
      failures++;
      $display("FAIL mid_reach: symbols=%0d required 200 (timeout)", rx_cnt_g);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("midreset_outs");
    lane_q.push_back(2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b = bursts_started;
    wait_bursts(b + 1, "mid_fresh");
    req = '0;
    wait_eops(e + 1, "mid_done");

    // Closing checks
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0 || lane_q.size() != 0) begin
      failures++;
      $display("FAIL leftovers: exp_q=%0d lane_q=%0d required 0/0", exp_q.size(), lane_q.size());
    end
    checks++;
    if (stray_count != 1) begin
      failures++;
      $display("FAIL stray_total: got %0d required 1", stray_count);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
